// File: rtl/axi_lite_write_router_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_write_router_pkg
//   Shared definitions for the AXI4-Lite write router and its address decoder:
//   BRESP encodings and the router state encoding.
// ---------------------------------------------------------------------------
package axi_lite_write_router_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The ST_ prefix keeps ST_RESP from colliding with the RESP width parameter.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_RESP  = 3'd2,
        ST_ERR_W = 3'd3,
        ST_ERR_B = 3'd4
    } state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// ---------------------------------------------------------------------------
// axi_lite_addr_decode
//   Combinational slave decoder shared by the write and read routers.
//   Ports:
//     addr   in  ADDR   transaction address
//     sel    out SEL_W  slave index taken from addr[SEL_LSB +: SEL_W]
//     decerr out 1      index does not map to an existing slave
// ---------------------------------------------------------------------------
module axi_lite_addr_decode #(
    parameter int ADDR     = 32,
    parameter int SEL_W    = 3,
    parameter int SEL_LSB  = 28,
    parameter int N_SLAVES = 6
) (
    input  logic [ADDR-1:0]  addr,
    output logic [SEL_W-1:0] sel,
    output logic             decerr
);

    // Only the index field matters; the rest of the address is folded here
    // so the unused bits are visibly accounted for.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

    assign sel    = addr[SEL_LSB +: SEL_W];
    assign decerr = (int'(sel) >= N_SLAVES);

endmodule

// File: rtl/axi_lite_write_router.sv
// ---------------------------------------------------------------------------
// axi_lite_write_router
//   AXI4-Lite write-channel router: one master port (M00) fanned out to
//   N_SLAVES slave ports, selected by AWADDR[SEL_LSB +: SEL_W]. One write is
//   tracked end to end (AW, W, B). Unmapped addresses get a local DECERR.
//
//   Ports:
//     ACLK, ARESET                   clock, synchronous active-high reset
//     M00_AW*/M00_W*/M00_B*          master-side write address/data/response
//     S_AW*/S_W*/S_B*                slave-side buses, slice i = slave i
//
//   Build option: define WRITE_TIMEOUT_EN to abandon a slave that has not
//   finished within TIMEOUT cycles of FWD entry; the master then gets SLVERR.
// ---------------------------------------------------------------------------
module axi_lite_write_router
    import axi_lite_write_router_pkg::*;
#(
    parameter int ADDR     = 32,
    parameter int DATA     = 32,
    parameter int STRB     = DATA / 8,
    parameter int PROT     = 3,
    parameter int RESP     = 2,
    parameter int N_SLAVES = 6,
    parameter int SEL_W    = 3,
    parameter int SEL_LSB  = 28,
    parameter int TIMEOUT  = 255
) (
    input  logic                     ACLK,
    input  logic                     ARESET,

    input  logic [ADDR-1:0]          M00_AWADDR,
    input  logic [PROT-1:0]          M00_AWPROT,
    input  logic                     M00_AWVALID,
    output logic                     M00_AWREADY,
    input  logic [DATA-1:0]          M00_WDATA,
    input  logic [STRB-1:0]          M00_WSTRB,
    input  logic                     M00_WVALID,
    output logic                     M00_WREADY,
    output logic [RESP-1:0]          M00_BRESP,
    output logic                     M00_BVALID,
    input  logic                     M00_BREADY,

    output logic [N_SLAVES*ADDR-1:0] S_AWADDR,
    output logic [N_SLAVES*PROT-1:0] S_AWPROT,
    output logic [N_SLAVES-1:0]      S_AWVALID,
    input  logic [N_SLAVES-1:0]      S_AWREADY,
    output logic [N_SLAVES*DATA-1:0] S_WDATA,
    output logic [N_SLAVES*STRB-1:0] S_WSTRB,
    output logic [N_SLAVES-1:0]      S_WVALID,
    input  logic [N_SLAVES-1:0]      S_WREADY,
    input  logic [N_SLAVES*RESP-1:0] S_BRESP,
    input  logic [N_SLAVES-1:0]      S_BVALID,
    output logic [N_SLAVES-1:0]      S_BREADY
);

    state_t            state;
    logic [ADDR-1:0]   addr_q;
    logic [PROT-1:0]   prot_q;
    logic [SEL_W-1:0]  sel_q;
    logic              awready_q;
    logic              err_wready_q;
    logic              bvalid_q;
    logic [RESP-1:0]   bresp_q;
    logic              s_awvalid_q;
    logic              aw_done;
    logic              w_done;

    logic [SEL_W-1:0]  dec_sel;
    logic              dec_err;

    logic              sel_awready;
    logic              sel_wready;
    logic              sel_bvalid;
    logic [RESP-1:0]   sel_bresp;

    logic              in_fwd;
    logic              in_resp;
    logic              w_fwd;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              timeout_hit;

    axi_lite_addr_decode #(
        .ADDR     (ADDR),
        .SEL_W    (SEL_W),
        .SEL_LSB  (SEL_LSB),
        .N_SLAVES (N_SLAVES)
    ) u_decode (
        .addr   (M00_AWADDR),
        .sel    (dec_sel),
        .decerr (dec_err)
    );

    assign in_fwd  = (state == ST_FWD);
    assign in_resp = (state == ST_RESP);
    // W is a straight combinational pass-through until its beat is taken.
    assign w_fwd   = in_fwd && !w_done;

    assign aw_hs = in_fwd && s_awvalid_q && sel_awready;
    assign w_hs  = w_fwd && M00_WVALID && sel_wready;
    assign b_hs  = in_resp && sel_bvalid && M00_BREADY;

    // Slave fan-out and fan-in. Only the selected slice carries anything;
    // every other slice sits at zero.
    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        S_AWADDR    = '0;
        S_AWPROT    = '0;
        S_AWVALID   = '0;
        S_WDATA     = '0;
        S_WSTRB     = '0;
        S_WVALID    = '0;
        S_BREADY    = '0;
        sel_awready = 1'b0;
        sel_wready  = 1'b0;
        sel_bvalid  = 1'b0;
        sel_bresp   = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (int'(sel_q) == i) begin
                S_AWADDR[i*ADDR +: ADDR] = addr_q;
                S_AWPROT[i*PROT +: PROT] = prot_q;
                S_WDATA[i*DATA +: DATA]  = M00_WDATA;
                S_WSTRB[i*STRB +: STRB]  = M00_WSTRB;
                S_AWVALID[i]             = in_fwd && s_awvalid_q;
                S_WVALID[i]              = w_fwd && M00_WVALID;
                S_BREADY[i]              = in_resp && M00_BREADY;
                sel_awready              = S_AWREADY[i];
                sel_wready               = S_WREADY[i];
                sel_bvalid               = S_BVALID[i];
                sel_bresp                = S_BRESP[i*RESP +: RESP];
            end
        end
    end

    assign M00_AWREADY = awready_q;
    assign M00_WREADY  = w_fwd ? sel_wready : err_wready_q;
    assign M00_BVALID  = in_resp ? sel_bvalid : bvalid_q;
    assign M00_BRESP   = in_resp ? sel_bresp  : bresp_q;

`ifdef WRITE_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TO_W-1:0] to_cnt;

    // Fires on the edge that would take the count to TIMEOUT, so the error
    // response becomes visible exactly TIMEOUT cycles after FWD entry.
    assign timeout_hit = (in_fwd || in_resp) && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            to_cnt <= '0;
        end else if (in_fwd || in_resp) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // NOTE: state and registered outputs use non-blocking assignments so all
    // of them update together on the edge; ARESET is sampled on that same
    // edge (synchronous) rather than in the sensitivity list.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            prot_q       <= '0;
            sel_q        <= '0;
            awready_q    <= 1'b0;
            err_wready_q <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= '0;
            s_awvalid_q  <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (M00_AWVALID && awready_q) begin
                        awready_q <= 1'b0;
                        addr_q    <= M00_AWADDR;
                        prot_q    <= M00_AWPROT;
                        sel_q     <= dec_sel;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (dec_err) begin
                            state        <= ST_ERR_W;
                            err_wready_q <= 1'b1;
                            bresp_q      <= RESP'(RESP_DECERR);
                        end else begin
                            state       <= ST_FWD;
                            s_awvalid_q <= 1'b1;
                        end
                    end else begin
                        awready_q <= 1'b1;
                    end
                end

                ST_FWD: begin
                    if (timeout_hit) begin
                        // Abandon the slave; a W beat the master still owes
                        // is drained locally before the error response.
                        s_awvalid_q <= 1'b0;
                        bresp_q     <= RESP'(RESP_SLVERR);
                        if (w_done || w_hs) begin
                            state    <= ST_ERR_B;
                            bvalid_q <= 1'b1;
                        end else begin
                            state        <= ST_ERR_W;
                            err_wready_q <= 1'b1;
                        end
                    end else begin
                        if (aw_hs) begin
                            s_awvalid_q <= 1'b0;
                            aw_done     <= 1'b1;
                        end
                        if (w_hs) begin
                            w_done <= 1'b1;
                        end
                        // AW and W may finish in either order or together.
                        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                            state <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    if (b_hs) begin
                        state     <= ST_IDLE;
                        awready_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state    <= ST_ERR_B;
                        bvalid_q <= 1'b1;
                        bresp_q  <= RESP'(RESP_SLVERR);
                    end
                end

                ST_ERR_W: begin
                    if (M00_WVALID && err_wready_q) begin
                        err_wready_q <= 1'b0;
                        state        <= ST_ERR_B;
                        bvalid_q     <= 1'b1;
                    end
                end

                ST_ERR_B: begin
                    if (M00_BREADY && bvalid_q) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP'(RESP_OKAY);
                        state     <= ST_IDLE;
                        awready_q <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_write_router.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_write_router
//   Directed bench for axi_lite_write_router (6 slaves, index in AWADDR[30:28]).
//   Slave-side handshakes are driven by hand in each scenario task.
// ---------------------------------------------------------------------------
module tb_axi_lite_write_router;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [31:0]   M00_AWADDR;
    logic [2:0]    M00_AWPROT;
    logic          M00_AWVALID;
    logic          M00_AWREADY;
    logic [31:0]   M00_WDATA;
    logic [3:0]    M00_WSTRB;
    logic          M00_WVALID;
    logic          M00_WREADY;
    logic [1:0]    M00_BRESP;
    logic          M00_BVALID;
    logic          M00_BREADY;
    logic [191:0]  S_AWADDR;
    logic [17:0]   S_AWPROT;
    logic [5:0]    S_AWVALID;
    logic [5:0]    S_AWREADY;
    logic [191:0]  S_WDATA;
    logic [23:0]   S_WSTRB;
    logic [5:0]    S_WVALID;
    logic [5:0]    S_WREADY;
    logic [11:0]   S_BRESP;
    logic [5:0]    S_BVALID;
    logic [5:0]    S_BREADY;

    int total = 0;
    int bad   = 0;
    int b_count = 0;

    axi_lite_write_router #(.TIMEOUT(16)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .M00_AWADDR  (M00_AWADDR),
        .M00_AWPROT  (M00_AWPROT),
        .M00_AWVALID (M00_AWVALID),
        .M00_AWREADY (M00_AWREADY),
        .M00_WDATA   (M00_WDATA),
        .M00_WSTRB   (M00_WSTRB),
        .M00_WVALID  (M00_WVALID),
        .M00_WREADY  (M00_WREADY),
        .M00_BRESP   (M00_BRESP),
        .M00_BVALID  (M00_BVALID),
        .M00_BREADY  (M00_BREADY),
        .S_AWADDR    (S_AWADDR),
        .S_AWPROT    (S_AWPROT),
        .S_AWVALID   (S_AWVALID),
        .S_AWREADY   (S_AWREADY),
        .S_WDATA     (S_WDATA),
        .S_WSTRB     (S_WSTRB),
        .S_WVALID    (S_WVALID),
        .S_WREADY    (S_WREADY),
        .S_BRESP     (S_BRESP),
        .S_BVALID    (S_BVALID),
        .S_BREADY    (S_BREADY)
    );

    always #5 ACLK = ~ACLK;

    // Counts master-side B handshakes; sampled mid-cycle when inputs are stable.
    always @(negedge ACLK) begin
        if (!ARESET && M00_BVALID && M00_BREADY) b_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        M00_AWADDR  = '0;
        M00_AWPROT  = '0;
        M00_AWVALID = 1'b0;
        M00_WDATA   = '0;
        M00_WSTRB   = '0;
        M00_WVALID  = 1'b0;
        M00_BREADY  = 1'b0;
        S_AWREADY   = '0;
        S_WREADY    = '0;
        S_BRESP     = '0;
        S_BVALID    = '0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        total++; if (M00_AWREADY !== 1'b0) begin bad++; $display("FAIL rst_awready got=%b want=0", M00_AWREADY); end
        total++; if (M00_WREADY !== 1'b0) begin bad++; $display("FAIL rst_wready got=%b want=0", M00_WREADY); end
        total++; if (M00_BVALID !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b want=0", M00_BVALID); end
        total++; if (M00_BRESP !== 2'b00) begin bad++; $display("FAIL rst_bresp got=%b want=00", M00_BRESP); end
        total++; if ({S_AWVALID, S_WVALID, S_BREADY} !== 18'h0) begin bad++; $display("FAIL rst_slave_vr got=%h want=0", {S_AWVALID, S_WVALID, S_BREADY}); end
        ARESET = 1'b0;
        #1;
        total++; if (M00_AWREADY !== 1'b0) begin bad++; $display("FAIL rst_release_awready got=%b want=0", M00_AWREADY); end
        cyc();
        total++; if (M00_AWREADY !== 1'b1) begin bad++; $display("FAIL rst_idle_awready got=%b want=1", M00_AWREADY); end
    endtask

    task automatic test_basic();
        int b_before;
        b_before  = b_count;
        S_AWREADY = 6'b111111;
        S_WREADY  = 6'b111111;
        S_BVALID  = 6'b111011;       // other slaves shouting; must be ignored
        S_BRESP   = 12'hFCF;         // slice 2 = OKAY, others = 11
        M00_AWADDR  = 32'h2000_0010;
        M00_AWPROT  = 3'b010;
        M00_AWVALID = 1'b1;
        M00_WDATA   = 32'hDEAD_BEEF;
        M00_WSTRB   = 4'hF;
        M00_WVALID  = 1'b1;
        #1;
        total++; if (M00_WREADY !== 1'b0) begin bad++; $display("FAIL basic_idle_wready got=%b want=0", M00_WREADY); end
        cyc();
        M00_AWVALID = 1'b0;
        #1;
        total++; if (S_AWVALID !== 6'b000100) begin bad++; $display("FAIL basic_awvalid got=%b want=000100", S_AWVALID); end
        total++; if (S_WVALID !== 6'b000100) begin bad++; $display("FAIL basic_wvalid got=%b want=000100", S_WVALID); end
        total++; if (M00_WREADY !== 1'b1) begin bad++; $display("FAIL basic_wready got=%b want=1", M00_WREADY); end
        total++; if (M00_AWREADY !== 1'b0) begin bad++; $display("FAIL basic_awready_busy got=%b want=0", M00_AWREADY); end
        total++; if (S_AWADDR[64 +: 32] !== 32'h2000_0010) begin bad++; $display("FAIL basic_awaddr got=%h want=20000010", S_AWADDR[64 +: 32]); end
        total++; if (S_AWPROT[6 +: 3] !== 3'b010) begin bad++; $display("FAIL basic_awprot got=%b want=010", S_AWPROT[6 +: 3]); end
        total++; if (S_WDATA[64 +: 32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_wdata got=%h want=deadbeef", S_WDATA[64 +: 32]); end
        total++; if (S_WSTRB[8 +: 4] !== 4'hF) begin bad++; $display("FAIL basic_wstrb got=%h want=f", S_WSTRB[8 +: 4]); end
        total++; if (S_AWADDR[0 +: 32] !== 32'h0) begin bad++; $display("FAIL basic_unsel_addr got=%h want=0", S_AWADDR[0 +: 32]); end
        total++; if (M00_BVALID !== 1'b0) begin bad++; $display("FAIL basic_fwd_bvalid got=%b want=0", M00_BVALID); end
        cyc();
        M00_WVALID = 1'b0;
        M00_BREADY = 1'b1;
        #1;
        total++; if ({S_AWVALID, S_WVALID} !== 12'h0) begin bad++; $display("FAIL basic_resp_valids got=%h want=0", {S_AWVALID, S_WVALID}); end
        total++; if (M00_BVALID !== 1'b0) begin bad++; $display("FAIL basic_resp_wait_bvalid got=%b want=0", M00_BVALID); end
        total++; if (S_BREADY !== 6'b000100) begin bad++; $display("FAIL basic_bready got=%b want=000100", S_BREADY); end
        S_BVALID = 6'b111111;
        #1;
        total++; if ({M00_BVALID, M00_BRESP} !== 3'b100) begin bad++; $display("FAIL basic_b got=%b want=100", {M00_BVALID, M00_BRESP}); end
        cyc();
        S_BVALID   = '0;
        M00_BREADY = 1'b0;
        #1;
        total++; if (M00_AWREADY !== 1'b1) begin bad++; $display("FAIL basic_back_idle got=%b want=1", M00_AWREADY); end
        total++; if ({M00_BVALID, S_BREADY} !== 7'h0) begin bad++; $display("FAIL basic_b_done got=%b want=0", {M00_BVALID, S_BREADY}); end
        total++; if (b_count - b_before !== 1) begin bad++; $display("FAIL basic_b_count got=%0d want=1", b_count - b_before); end
        idle_inputs();
    endtask

    task automatic test_w_first();
        S_AWREADY  = 6'b111111;
        S_WREADY   = 6'b111111;
        M00_WDATA  = 32'h1234_5678;
        M00_WSTRB  = 4'b0110;
        M00_WVALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if ({M00_WREADY, S_WVALID} !== 7'h0) begin bad++; $display("FAIL wfirst_wait%0d got=%b want=0", k, {M00_WREADY, S_WVALID}); end
            cyc();
        end
        M00_AWADDR  = 32'h5000_0000;
        M00_AWVALID = 1'b1;
        #1;
        total++; if (M00_WREADY !== 1'b0) begin bad++; $display("FAIL wfirst_aw_cycle got=%b want=0", M00_WREADY); end
        cyc();
        M00_AWVALID = 1'b0;
        #1;
        total++; if (M00_WREADY !== 1'b1) begin bad++; $display("FAIL wfirst_wready got=%b want=1", M00_WREADY); end
        total++; if (S_WVALID !== 6'b100000) begin bad++; $display("FAIL wfirst_wvalid got=%b want=100000", S_WVALID); end
        total++; if (S_AWVALID !== 6'b100000) begin bad++; $display("FAIL wfirst_awvalid got=%b want=100000", S_AWVALID); end
        total++; if ({S_WDATA[160 +: 32], S_WSTRB[20 +: 4]} !== 36'h1_2345_6786) begin bad++; $display("FAIL wfirst_data got=%h want=123456786", {S_WDATA[160 +: 32], S_WSTRB[20 +: 4]}); end
        cyc();
        M00_WVALID = 1'b0;
        S_BVALID   = 6'b100000;
        M00_BREADY = 1'b1;
        #1;
        total++; if ({M00_BVALID, M00_BRESP} !== 3'b100) begin bad++; $display("FAIL wfirst_b got=%b want=100", {M00_BVALID, M00_BRESP}); end
        cyc();
        idle_inputs();
        #1;
        total++; if (M00_AWREADY !== 1'b1) begin bad++; $display("FAIL wfirst_idle got=%b want=1", M00_AWREADY); end
    endtask

    task automatic test_decerr();
        S_AWREADY   = 6'b111111;
        S_WREADY    = 6'b111111;
        S_BVALID    = 6'b111111;
        M00_AWADDR  = 32'h7000_0000;
        M00_AWVALID = 1'b1;
        cyc();
        M00_AWVALID = 1'b0;
        #1;
        total++; if ({S_AWVALID, S_WVALID, S_BREADY} !== 18'h0) begin bad++; $display("FAIL decerr_errw_slaves got=%h want=0", {S_AWVALID, S_WVALID, S_BREADY}); end
        total++; if ({M00_AWREADY, M00_WREADY, M00_BVALID} !== 3'b010) begin bad++; $display("FAIL decerr_errw got=%b want=010", {M00_AWREADY, M00_WREADY, M00_BVALID}); end
        M00_WDATA  = 32'h0BAD_F00D;
        M00_WSTRB  = 4'hF;
        M00_WVALID = 1'b1;
        cyc();
        M00_WVALID = 1'b0;
        #1;
        total++; if ({M00_WREADY, M00_BVALID, M00_BRESP} !== 4'b0111) begin bad++; $display("FAIL decerr_b got=%b want=0111", {M00_WREADY, M00_BVALID, M00_BRESP}); end
        total++; if ({S_AWVALID, S_WVALID, S_BREADY} !== 18'h0) begin bad++; $display("FAIL decerr_errb_slaves got=%h want=0", {S_AWVALID, S_WVALID, S_BREADY}); end
        cyc();
        total++; if ({M00_BVALID, M00_BRESP} !== 3'b111) begin bad++; $display("FAIL decerr_hold got=%b want=111", {M00_BVALID, M00_BRESP}); end
        M00_BREADY = 1'b1;
        cyc();
        M00_BREADY = 1'b0;
        #1;
        total++; if ({M00_AWREADY, M00_BVALID, M00_BRESP} !== 4'b1000) begin bad++; $display("FAIL decerr_done got=%b want=1000", {M00_AWREADY, M00_BVALID, M00_BRESP}); end
        idle_inputs();
    endtask

    task automatic test_slow_slave();
        int b_before;
        b_before    = b_count;
        M00_AWADDR  = 32'h1000_0004;
        M00_AWVALID = 1'b1;
        M00_WDATA   = 32'hCAFE_0001;
        M00_WSTRB   = 4'b0011;
        M00_WVALID  = 1'b1;
        S_WREADY    = 6'b000010;
        cyc();
        M00_AWVALID = 1'b0;
        #1;
        total++; if (S_AWVALID !== 6'b000010) begin bad++; $display("FAIL slow_awvalid got=%b want=000010", S_AWVALID); end
        total++; if (S_AWADDR[32 +: 32] !== 32'h1000_0004) begin bad++; $display("FAIL slow_awaddr got=%h want=10000004", S_AWADDR[32 +: 32]); end
        cyc();
        M00_WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if ({S_AWVALID, S_WVALID} !== 12'b000010_000000) begin bad++; $display("FAIL slow_aw_stable%0d got=%b want=000010000000", k, {S_AWVALID, S_WVALID}); end
            cyc();
        end
        S_AWREADY = 6'b000010;
        cyc();
        S_AWREADY  = '0;
        M00_BREADY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            total++; if ({S_BREADY, M00_BVALID, S_AWVALID} !== 13'b000010_0_000000) begin bad++; $display("FAIL slow_b_wait%0d got=%b want=0000100000000", k, {S_BREADY, M00_BVALID, S_AWVALID}); end
            cyc();
        end
        S_BVALID   = 6'b000010;
        S_BRESP    = 12'h004;        // slice 1 = 01 passes through unchanged
        M00_BREADY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if ({M00_BVALID, M00_BRESP, S_BREADY} !== 9'b1_01_000000) begin bad++; $display("FAIL slow_b_hold%0d got=%b want=101000000", k, {M00_BVALID, M00_BRESP, S_BREADY}); end
            cyc();
        end
        M00_BREADY = 1'b1;
        #1;
        total++; if (S_BREADY !== 6'b000010) begin bad++; $display("FAIL slow_bready_mirror got=%b want=000010", S_BREADY); end
        cyc();
        idle_inputs();
        #1;
        total++; if (b_count - b_before !== 1) begin bad++; $display("FAIL slow_b_count got=%0d want=1", b_count - b_before); end
        total++; if ({M00_AWREADY, M00_BVALID} !== 2'b10) begin bad++; $display("FAIL slow_idle got=%b want=10", {M00_AWREADY, M00_BVALID}); end
    endtask

    task automatic test_reset_mid();
        S_AWREADY   = 6'b111111;
        S_WREADY    = 6'b111111;
        M00_AWADDR  = 32'h0000_0000;
        M00_AWVALID = 1'b1;
        M00_WVALID  = 1'b1;
        cyc();
        M00_AWVALID = 1'b0;
        cyc();
        M00_WVALID = 1'b0;
        M00_BREADY = 1'b1;
        #1;
        total++; if (S_BREADY !== 6'b000001) begin bad++; $display("FAIL rmid_in_resp got=%b want=000001", S_BREADY); end
        ARESET     = 1'b1;
        M00_WVALID = 1'b1;
        cyc();
        total++; if ({S_AWVALID, S_WVALID, S_BREADY} !== 18'h0) begin bad++; $display("FAIL rmid_slaves got=%h want=0", {S_AWVALID, S_WVALID, S_BREADY}); end
        total++; if ({M00_AWREADY, M00_WREADY, M00_BVALID} !== 3'b000) begin bad++; $display("FAIL rmid_master got=%b want=000", {M00_AWREADY, M00_WREADY, M00_BVALID}); end
        ARESET = 1'b0;
        idle_inputs();
        cyc();
        total++; if (M00_AWREADY !== 1'b1) begin bad++; $display("FAIL rmid_release got=%b want=1", M00_AWREADY); end
    endtask

`ifdef WRITE_TIMEOUT_EN
    task automatic test_timeout();
        // Scenario 0: slave 3 takes W but never AW -> SLVERR exactly 16 cycles
        // after FWD entry. Scenario 1: slave 3 takes nothing -> W drained first.
        for (int sc = 0; sc < 2; sc++) begin
            int  got_at;
            bit  drained;
            got_at  = 0;
            drained = 1'b0;
            idle_inputs();
            S_WREADY    = (sc == 0) ? 6'b001000 : 6'b000000;
            M00_AWADDR  = 32'h3000_0000;
            M00_AWVALID = 1'b1;
            M00_WVALID  = 1'b1;
            cyc();
            M00_AWVALID = 1'b0;
            for (int k = 1; k <= 40 && got_at == 0; k++) begin
                cyc();
                if (sc == 0) M00_WVALID = 1'b0;
                #1;
                if (M00_WREADY && !M00_BVALID && S_WVALID == 6'b0) drained = 1'b1;
                if (M00_BVALID) got_at = k;
            end
            M00_WVALID = 1'b0;
            total++; if (M00_BRESP !== 2'b10) begin bad++; $display("FAIL timeout%0d_bresp got=%b want=10", sc, M00_BRESP); end
            total++; if ({S_AWVALID, S_WVALID, S_BREADY} !== 18'h0) begin bad++; $display("FAIL timeout%0d_slaves got=%h want=0", sc, {S_AWVALID, S_WVALID, S_BREADY}); end
            if (sc == 0) begin
                total++; if (got_at !== 16) begin bad++; $display("FAIL timeout0_latency got=%0d want=16", got_at); end
            end else begin
                total++; if (drained !== 1'b1) begin bad++; $display("FAIL timeout1_drain got=%b want=1", drained); end
                total++; if (got_at < 16 || got_at > 18) begin bad++; $display("FAIL timeout1_latency got=%0d want=16..18", got_at); end
            end
            M00_BREADY = 1'b1;
            cyc();
            M00_BREADY = 1'b0;
            #1;
            total++; if ({M00_AWREADY, M00_BVALID} !== 2'b10) begin bad++; $display("FAIL timeout%0d_idle got=%b want=10", sc, {M00_AWREADY, M00_BVALID}); end
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_w_first();
        test_decerr();
        test_slow_slave();
        test_reset_mid();
`ifdef WRITE_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
